// File: rtl/xy_noc_pkg.sv
// Shared constants for the mesh XY switch: port indices,
// flit header layout and the route/arbitration FSM encoding.
package xy_noc_pkg;

    localparam int PORT_LOCAL = 0;
    localparam int PORT_NORTH = 1;
    localparam int PORT_EAST  = 2;
    localparam int PORT_SOUTH = 3;
    localparam int PORT_WEST  = 4;

    localparam int HDR_COL_OFS = 0;
    localparam int HDR_COL_W   = 2;
    localparam int HDR_ROW_W   = 2;

    localparam int CNT_W = 8;

    localparam logic [0:0] ST_ARB   = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

endpackage

// File: rtl/xy_route_arbiter_if.sv
// Request/grant bundle between control_unit and xy_route_arbiter.
// grant_cnt_o exists only when XY_ARB_GRANT_CNT_EN is defined.
interface xy_route_arbiter_if
    import xy_noc_pkg::*;
#(
    parameter int INPUT_N    = 5,
    parameter int DATA_WIDTH = 8
);
    localparam int SEL_W = $clog2(INPUT_N);

    logic [INPUT_N-1:0]            vld_input_i;
    logic [INPUT_N*DATA_WIDTH-1:0] data_i;
    logic [INPUT_N-1:0]            vld_output_i;
    logic [SEL_W-1:0]              mux_in_sel_o;
    logic [SEL_W-1:0]              mux_out_sel_o;
    logic                          grant_vld_o;
`ifdef XY_ARB_GRANT_CNT_EN
    logic [INPUT_N*CNT_W-1:0]      grant_cnt_o;
`endif

    modport master (
        output vld_input_i, data_i, vld_output_i,
        input  mux_in_sel_o, mux_out_sel_o, grant_vld_o
`ifdef XY_ARB_GRANT_CNT_EN
        , input grant_cnt_o
`endif
    );

    modport slave (
        input  vld_input_i, data_i, vld_output_i,
        output mux_in_sel_o, mux_out_sel_o, grant_vld_o
`ifdef XY_ARB_GRANT_CNT_EN
        , output grant_cnt_o
`endif
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or above ptr,
// wrapping from N-1 back to 0.
module rr_arbiter #(
    parameter int N = 5
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);
    localparam int W = $clog2(N);

    logic [W:0] c;

    always_comb begin
        idx = '0;
        any = 1'b0;
        c   = '0;
        for (int i = 0; i < N; i++) begin
            c = {1'b0, ptr} + (W+1)'(i);
            if (c >= (W+1)'(N)) c = c - (W+1)'(N);
            if (!any && req[c[W-1:0]]) begin
                any = 1'b1;
                idx = c[W-1:0];
            end
        end
    end

endmodule

// File: rtl/xy_route_arbiter.sv
// XY route compute + round-robin grant for the mesh switch.
// Define XY_ARB_GRANT_CNT_EN to add saturating per-input grant counters.
module xy_route_arbiter
    import xy_noc_pkg::*;
#(
    parameter int INPUT_N        = 5,
    parameter int DATA_WIDTH     = 8,
    parameter int COL_ADDR_WIDTH = HDR_COL_W,
    parameter int ROW_ADDR_WIDTH = HDR_ROW_W,
    parameter int COL_CORD       = 0,
    parameter int ROW_CORD       = 0
) (
    input logic               clk_i,
    input logic               rst_ni,
    xy_route_arbiter_if.slave bus
);
    localparam int SEL_W   = $clog2(INPUT_N);
    localparam int ROW_OFS = HDR_COL_OFS + COL_ADDR_WIDTH;
    localparam logic [COL_ADDR_WIDTH-1:0] MY_COL = COL_ADDR_WIDTH'(COL_CORD);
    localparam logic [ROW_ADDR_WIDTH-1:0] MY_ROW = ROW_ADDR_WIDTH'(ROW_CORD);

    logic [SEL_W-1:0]          route [INPUT_N];
    logic [INPUT_N-1:0]        req;
    logic [COL_ADDR_WIDTH-1:0] col;
    logic [ROW_ADDR_WIDTH-1:0] row;
    logic [SEL_W-1:0]          win;
    logic                      any;
    logic                      fire;

    logic [0:0]       state;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] in_sel;
    logic [SEL_W-1:0] out_sel;
    logic             gvld;
    logic             unused_data;

    assign unused_data = ^bus.data_i;

    // A busy target output masks the request so it cannot block others.
    always_comb begin
        req = '0;
        col = '0;
        row = '0;
        for (int k = 0; k < INPUT_N; k++) begin
            col = bus.data_i[k*DATA_WIDTH+HDR_COL_OFS +: COL_ADDR_WIDTH];
            row = bus.data_i[k*DATA_WIDTH+ROW_OFS +: ROW_ADDR_WIDTH];
            if (col > MY_COL)      route[k] = SEL_W'(PORT_EAST);
            else if (col < MY_COL) route[k] = SEL_W'(PORT_WEST);
            else if (row > MY_ROW) route[k] = SEL_W'(PORT_SOUTH);
            else if (row < MY_ROW) route[k] = SEL_W'(PORT_NORTH);
            else                   route[k] = SEL_W'(PORT_LOCAL);
            req[k] = bus.vld_input_i[k] & ~bus.vld_output_i[route[k]];
        end
    end

    rr_arbiter #(
        .N (INPUT_N)
    ) u_rr (
        .req (req),
        .ptr (rr_ptr),
        .idx (win),
        .any (any)
    );

    assign fire = (state == ST_ARB) && any;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= ST_ARB;
            rr_ptr  <= '0;
            in_sel  <= '0;
            out_sel <= '0;
            gvld    <= 1'b0;
        end else begin
            unique case (state)
                ST_ARB: begin
                    if (any) begin
                        in_sel  <= win;
                        out_sel <= route[win];
                        gvld    <= 1'b1;
                        state   <= ST_GRANT;
                        rr_ptr  <= (win == SEL_W'(INPUT_N-1)) ?
                                   '0 : win + SEL_W'(1);
                    end
                end
                ST_GRANT: begin
                    gvld  <= 1'b0;
                    state <= ST_ARB;
                end
                default: state <= ST_ARB;
            endcase
        end
    end

    assign bus.mux_in_sel_o  = in_sel;
    assign bus.mux_out_sel_o = out_sel;
    assign bus.grant_vld_o   = gvld;

`ifdef XY_ARB_GRANT_CNT_EN
    logic [CNT_W-1:0] cnt [INPUT_N];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < INPUT_N; k++) cnt[k] <= '0;
        end else if (fire) begin
            for (int k = 0; k < INPUT_N; k++)
                if (win == SEL_W'(k) && cnt[k] != '1)
                    cnt[k] <= cnt[k] + CNT_W'(1);
        end
    end

    for (genvar k = 0; k < INPUT_N; k++) begin : g_cnt
        assign bus.grant_cnt_o[k*CNT_W +: CNT_W] = cnt[k];
    end
`else
    logic unused_fire;
    assign unused_fire = fire;
`endif

endmodule

// File: tb/tb_xy_route_arbiter.sv
// Scoreboard bench for xy_route_arbiter at mesh position (1,1).
// Counter scenario runs only when XY_ARB_GRANT_CNT_EN is defined.
module tb_xy_route_arbiter;
    import xy_noc_pkg::*;

    typedef struct packed {
        logic [2:0] in_sel;
        logic [2:0] out_sel;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    xy_route_arbiter_if #(.INPUT_N(5), .DATA_WIDTH(8)) bus ();

    xy_route_arbiter #(
        .INPUT_N        (5),
        .DATA_WIDTH     (8),
        .COL_ADDR_WIDTH (2),
        .ROW_ADDR_WIDTH (2),
        .COL_CORD       (1),
        .ROW_CORD       (1)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    task automatic idle();
        bus.vld_input_i  = '0;
        bus.data_i       = '0;
        bus.vld_output_i = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic take_grant(input int budget, output bit ok, output exp_t e);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            ok = (bus.grant_vld_o === 1'b1);
        end
        e = (sb.size() > 0) ? sb.pop_front() : '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.vld_input_i  = '1;
        bus.data_i       = {5{8'h07}};
        bus.vld_output_i = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.grant_vld_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_gvld: got %b want 0", bus.grant_vld_o);
        end
        checks++;
        if (bus.mux_in_sel_o !== 3'd0) begin
            errors++;
            $display("FAIL reset_in_sel: got %0d want 0", bus.mux_in_sel_o);
        end
        checks++;
        if (bus.mux_out_sel_o !== 3'd0) begin
            errors++;
            $display("FAIL reset_out_sel: got %0d want 0", bus.mux_out_sel_o);
        end
`ifdef XY_ARB_GRANT_CNT_EN
        checks++;
        if (bus.grant_cnt_o !== 40'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %h want 0", bus.grant_cnt_o);
        end
`endif
        idle();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (bus.grant_vld_o !== 1'b0) begin
                errors++;
                $display("FAIL idle_gvld: cycle %0d got %b want 0", i, bus.grant_vld_o);
            end
        end
    endtask

    task automatic test_east();
        bit   ok;
        exp_t e;
        bus.data_i[7:0] = 8'h07;
        bus.vld_input_i = 5'b00001;
        sb.push_back({3'd0, 3'd2});
        take_grant(4, ok, e);
        idle();
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL east_grant: grant_vld_o got 0 want 1 within 4 cycles");
        end else begin
            checks++;
            if (bus.mux_in_sel_o !== e.in_sel) begin
                errors++;
                $display("FAIL east_in: got %0d want %0d", bus.mux_in_sel_o, e.in_sel);
            end
            checks++;
            if (bus.mux_out_sel_o !== e.out_sel) begin
                errors++;
                $display("FAIL east_out: got %0d want %0d", bus.mux_out_sel_o, e.out_sel);
            end
            @(negedge clk);
            checks++;
            if (bus.grant_vld_o !== 1'b0) begin
                errors++;
                $display("FAIL east_pulse: gvld got %b want 0", bus.grant_vld_o);
            end
            checks++;
            if (bus.mux_out_sel_o !== e.out_sel) begin
                errors++;
                $display("FAIL east_hold: out got %0d want %0d", bus.mux_out_sel_o, e.out_sel);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_local();
        bit   ok;
        exp_t e;
        bus.data_i[31:24] = 8'h05;
        bus.vld_input_i   = 5'b01000;
        sb.push_back({3'd3, 3'd0});
        take_grant(4, ok, e);
        idle();
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL local_grant: grant_vld_o got 0 want 1 within 4 cycles");
        end else begin
            checks++;
            if (bus.mux_in_sel_o !== e.in_sel) begin
                errors++;
                $display("FAIL local_in: got %0d want %0d", bus.mux_in_sel_o, e.in_sel);
            end
            checks++;
            if (bus.mux_out_sel_o !== e.out_sel) begin
                errors++;
                $display("FAIL local_out: got %0d want %0d", bus.mux_out_sel_o, e.out_sel);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit   ok;
        exp_t e;
        int   c1;
        apply_reset();
        bus.data_i[15:8]  = 8'h04;
        bus.data_i[23:16] = 8'h04;
        bus.vld_input_i   = 5'b00110;
        sb.push_back({3'd1, 3'd4});
        sb.push_back({3'd2, 3'd4});
        sb.push_back({3'd3, 3'd4});
        for (int g = 0; g < 3; g++) begin
            take_grant(4, ok, e);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL rr_grant%0d: grant_vld_o got 0 want 1", g);
            end else begin
                checks++;
                if (bus.mux_in_sel_o !== e.in_sel) begin
                    errors++;
                    $display("FAIL rr_in%0d: got %0d want %0d", g, bus.mux_in_sel_o, e.in_sel);
                end
                checks++;
                if (bus.mux_out_sel_o !== e.out_sel) begin
                    errors++;
                    $display("FAIL rr_out%0d: got %0d want %0d", g, bus.mux_out_sel_o, e.out_sel);
                end
            end
            if (g == 1) begin
                checks++;
                if (cyc - c1 !== 2) begin
                    errors++;
                    $display("FAIL rr_gap: got %0d cycles want 2", cyc - c1);
                end
                bus.data_i      = {8'h04, 8'h04, 8'h04, 8'h04, 8'h00};
                bus.vld_input_i = 5'b11110;
            end
            c1 = cyc;
        end
        idle();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_busy_output();
        bit   ok;
        exp_t e;
        apply_reset();
        bus.data_i[7:0]   = 8'h07;
        bus.data_i[39:32] = 8'h01;
        bus.vld_input_i   = 5'b10001;
        bus.vld_output_i  = 5'b00100;
        sb.push_back({3'd4, 3'd1});
        take_grant(4, ok, e);
        bus.vld_input_i = 5'b00001;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL busy_grant4: grant_vld_o got 0 want 1");
        end else begin
            checks++;
            if (bus.mux_in_sel_o !== e.in_sel) begin
                errors++;
                $display("FAIL busy_in4: got %0d want %0d", bus.mux_in_sel_o, e.in_sel);
            end
            checks++;
            if (bus.mux_out_sel_o !== e.out_sel) begin
                errors++;
                $display("FAIL busy_out4: got %0d want %0d", bus.mux_out_sel_o, e.out_sel);
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus.grant_vld_o !== 1'b0) begin
                errors++;
                $display("FAIL busy_block: cycle %0d gvld got %b want 0", i, bus.grant_vld_o);
            end
        end
        bus.vld_output_i = '0;
        sb.push_back({3'd0, 3'd2});
        take_grant(4, ok, e);
        idle();
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL busy_grant0: grant_vld_o got 0 want 1");
        end else begin
            checks++;
            if (bus.mux_in_sel_o !== e.in_sel) begin
                errors++;
                $display("FAIL busy_in0: got %0d want %0d", bus.mux_in_sel_o, e.in_sel);
            end
            checks++;
            if (bus.mux_out_sel_o !== e.out_sel) begin
                errors++;
                $display("FAIL busy_out0: got %0d want %0d", bus.mux_out_sel_o, e.out_sel);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_grant();
        bit   ok;
        exp_t e;
        bus.data_i[7:0] = 8'h07;
        bus.vld_input_i = 5'b00001;
        sb.push_back({3'd0, 3'd2});
        take_grant(4, ok, e);
        checks++;
        if (!ok || bus.mux_out_sel_o !== e.out_sel) begin
            errors++;
            $display("FAIL mid_pre: gvld %b out %0d want 1 and %0d", bus.grant_vld_o, bus.mux_out_sel_o, e.out_sel);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.grant_vld_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_gvld: got %b want 0", bus.grant_vld_o);
        end
        checks++;
        if (bus.mux_in_sel_o !== 3'd0 || bus.mux_out_sel_o !== 3'd0) begin
            errors++;
            $display("FAIL mid_sel: in %0d out %0d want 0 0", bus.mux_in_sel_o, bus.mux_out_sel_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back({3'd0, 3'd2});
        take_grant(1, ok, e);
        idle();
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL mid_first: gvld got 0 want 1 one cycle after release");
        end else begin
            checks++;
            if (bus.mux_out_sel_o !== e.out_sel) begin
                errors++;
                $display("FAIL mid_first_out: got %0d want %0d", bus.mux_out_sel_o, e.out_sel);
            end
        end
        repeat (2) @(negedge clk);
    endtask

`ifdef XY_ARB_GRANT_CNT_EN
    task automatic test_grant_cnt();
        bit   ok;
        exp_t e;
        apply_reset();
        bus.data_i[7:0] = 8'h07;
        bus.vld_input_i = 5'b00001;
        for (int i = 1; i <= 300; i++) begin
            sb.push_back({3'd0, 3'd2});
            take_grant(4, ok, e);
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL cnt_grant: grant %0d gvld got 0 want 1", i);
                break;
            end
            if (i == 100) begin
                checks++;
                if (bus.grant_cnt_o[7:0] !== 8'd100) begin
                    errors++;
                    $display("FAIL cnt_100: got %0d want 100", bus.grant_cnt_o[7:0]);
                end
            end
        end
        idle();
        @(negedge clk);
        checks++;
        if (bus.grant_cnt_o[7:0] !== 8'd255) begin
            errors++;
            $display("FAIL cnt_sat: got %0d want 255", bus.grant_cnt_o[7:0]);
        end
        checks++;
        if (bus.grant_cnt_o[39:8] !== 32'd0) begin
            errors++;
            $display("FAIL cnt_other: got %h want 0", bus.grant_cnt_o[39:8]);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_east();
        test_local();
        test_back_to_back();
        test_busy_output();
        test_reset_mid_grant();
`ifdef XY_ARB_GRANT_CNT_EN
        test_grant_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
